// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus between the CPU load/store unit and the data RAM responder.
// The CPU drives requests through the master modport; the RAM answers through the slave modport.
interface data_mem_responder_if #(
    parameter int unsigned DATA_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;
    logic              mem_err;

    modport master (
        output mem_read,
        output mem_write,
        output addr,
        output write_data,
        input  read_data,
        input  mem_ready,
        input  mem_err
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr,
        input  write_data,
        output read_data,
        output mem_ready,
        output mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering one CPU load/store at a time after LATENCY wait cycles.
// Optional address fault checking is enabled by defining DMEM_ERR_CHECK_EN.
module data_mem_responder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 4
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // Left without reset so preloaded contents survive rst.
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              access;
    logic              mem_we;
    logic [ADDR_W-1:0] req_idx;
    logic              req_fault;

    assign req_idx = bus.addr[ADDR_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign req_fault = (bus.addr[1:0] != 2'b00) || (bus.addr[31:ADDR_W+2] != '0);
`else
    // Out-of-range and unaligned addresses simply wrap onto the word index.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
    assign req_fault   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.mem_read || bus.mem_write) begin
                    // A simultaneous read and write is handled as a store.
                    wr_d    = bus.mem_write;
                    idx_d   = req_idx;
                    wdata_d = bus.write_data;
                    fault_d = req_fault;
                    cnt_d   = CNT_INIT;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access  = 1'b1;
                    ready_d = 1'b1;
                    state_d = StResp;
                    if (!wr_q) begin
                        rdata_d = fault_q ? '0 : mem[idx_q];
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_we = access && wr_q && !fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Reset in the access cycle must still abort the store.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access && fault_q;
        end
    end

    assign bus.mem_err = err_q;
`else
    assign bus.mem_err = 1'b0;
`endif

    assign bus.read_data = rdata_q;
    assign bus.mem_ready = ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a shadow memory predicts each response.
module tb_data_mem_responder;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned CNT_W   = 4;

`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    data_mem_responder_if #(.DATA_W(DATA_W)) bus ();

    data_mem_responder #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LATENCY(LATENCY),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] model [0:31];
    logic [31:0] rd_model;
    exp_t        sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic model_fault(input logic [31:0] a);
        return ERR_EN && ((a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0));
    endfunction

    // Issue one request from IDLE, wait for its response and score it.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input bit toggle);
        exp_t            e;
        int              k;
        bit              seen;
        logic [ADDR_W-1:0] idx;
        logic            f;
        idx = a[ADDR_W+1:2];
        f   = model_fault(a);
        if (wr) begin
            if (!f) model[idx] = wd;
        end else begin
            rd_model = f ? 32'h0 : model[idx];
        end
        e.rd  = rd_model;
        e.err = f;
        sb.push_back(e);

        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.addr       = a;
        bus.write_data = wd;
        seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (toggle && k == 1) begin
                bus.write_data = ~wd;
                bus.addr       = a ^ 32'h4;
            end
            if (bus.mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_ready"}, 32'(bus.mem_ready), 32'h1);
        if (seen) check({tag, "_lat"}, 32'(k), 32'(LATENCY + 1));
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        e = sb.pop_front();
        check({tag, "_rdata"}, bus.read_data, e.rd);
        check({tag, "_err"}, 32'(bus.mem_err), 32'(e.err));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(bus.mem_ready), 32'h0);
    endtask

    initial begin
        int rdy_cnt;
        logic [31:0] ra;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.addr       = 32'h0;
        bus.write_data = 32'h0;
        for (int i = 0; i < 32; i++) model[i] = 32'hA000_0000 | 32'(i);
        model[1] = 32'hDEAD_BEEF;
        model[3] = 32'h1234_5678;
        for (int i = 0; i < 32; i++) dut.mem[i] = model[i];

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", bus.read_data, 32'h0);
        check("rst_ready", 32'(bus.mem_ready), 32'h0);
        check("rst_err", 32'(bus.mem_err), 32'h0);
        check("rst_mem3", dut.mem[3], 32'h1234_5678);
        rst      = 1'b0;
        rd_model = 32'h0;
        @(posedge clk);
        #1;

        access("ld1", 1'b1, 1'b0, 32'd4, 32'h0, 1'b0);
        access("st2", 1'b0, 1'b1, 32'd8, 32'h0000_00A5, 1'b0);
        access("ld2", 1'b1, 1'b0, 32'd8, 32'h0, 1'b0);
        access("st_tog", 1'b0, 1'b1, 32'd16, 32'hCAFE_F00D, 1'b1);
        access("ld_tog", 1'b1, 1'b0, 32'd16, 32'h0, 1'b0);
        access("ld_nb", 1'b1, 1'b0, 32'd20, 32'h0, 1'b0);
        access("both", 1'b1, 1'b1, 32'd24, 32'h5555_AAAA, 1'b0);
        access("ld_both", 1'b1, 1'b0, 32'd24, 32'h0, 1'b0);

        // Store aborted by reset while BUSY.
        bus.mem_write  = 1'b1;
        bus.addr       = 32'd12;
        bus.write_data = 32'hFFFF_FFFF;
        rdy_cnt = 0;
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.mem_write = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) rdy_cnt++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) rdy_cnt++;
        end
        rd_model = 32'h0;
        check("abort_noready", 32'(rdy_cnt), 32'h0);
        check("abort_mem3", dut.mem[3], model[3]);
        check("abort_rdata", bus.read_data, 32'h0);
        access("ld_mem3", 1'b1, 1'b0, 32'd12, 32'h0, 1'b0);

        access("ld_fault", 1'b1, 1'b0, 32'h0000_0082, 32'h0, 1'b0);
        access("st_hi", 1'b0, 1'b1, 32'h0000_0100, 32'h7777_0000, 1'b0);
        access("ld0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            ra = 32'($urandom_range(0, 31)) << 2;
            if ($urandom_range(0, 1) == 1)
                access("rnd_st", 1'b0, 1'b1, ra, $urandom, 1'b0);
            else
                access("rnd_ld", 1'b1, 1'b0, ra, 32'h0, 1'b0);
        end

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
